// File: rtl/multi_alarm_clock_if.sv
// multi_alarm_clock_if: load, control and display bundle for multi_alarm_clock.
//   master : drives time/alarm load fields, load strobes, enables, stop/snooze,
//            display mode; receives BCD display digits, pm and alarm flags.
//   slave  : the clock itself (mirror of master).
interface multi_alarm_clock_if #(
    parameter int unsigned N_ALARMS = 4
);
    localparam int unsigned AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;

    // Load fields (BCD) and controls
    logic [1:0]          hr_in_1;
    logic [3:0]          hr_in_0;
    logic [3:0]          min_in_1;
    logic [3:0]          min_in_0;
    logic                LD_time;
    logic                LD_alarm;
    logic [AW-1:0]       alarm_sel;
    logic [N_ALARMS-1:0] AL_EN;
    logic                STOP_alarm;
    logic                SNOOZE;
    logic                mode_12h;

    // Display and alarm outputs
    logic [1:0]          hr_out_1;
    logic [3:0]          hr_out_0;
    logic [3:0]          min_out_1;
    logic [3:0]          min_out_0;
    logic [3:0]          sec_out_1;
    logic [3:0]          sec_out_0;
    logic                pm;
    logic [N_ALARMS-1:0] ringing;
    logic                Alarm;

    modport master (
        output hr_in_1, hr_in_0, min_in_1, min_in_0, LD_time, LD_alarm, alarm_sel,
               AL_EN, STOP_alarm, SNOOZE, mode_12h,
        input  hr_out_1, hr_out_0, min_out_1, min_out_0, sec_out_1, sec_out_0, pm,
               ringing, Alarm
    );

    modport slave (
        input  hr_in_1, hr_in_0, min_in_1, min_in_0, LD_time, LD_alarm, alarm_sel,
               AL_EN, STOP_alarm, SNOOZE, mode_12h,
        output hr_out_1, hr_out_0, min_out_1, min_out_0, sec_out_1, sec_out_0, pm,
               ringing, Alarm
    );
endinterface

// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: 24-hour real-time clock with N_ALARMS programmable alarms,
// snooze and 12/24-hour display. A clock-enable counter produces one tick per
// CLK_DIV system cycles; no divided clock is generated.
// Ports:
//   clk      : system clock, all state changes on rising edge
//   areset_n : asynchronous active-low reset
//   bus      : multi_alarm_clock_if slave (load fields/controls in, BCD display,
//              pm, per-slot ringing and Alarm out)
module multi_alarm_clock #(
    parameter int unsigned CLK_DIV    = 10,
    parameter int unsigned N_ALARMS   = 4,
    parameter int unsigned SNOOZE_MIN = 5
) (
    input logic                 clk,
    input logic                 areset_n,
    multi_alarm_clock_if.slave  bus
);
    localparam int unsigned AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [6:0]    SNZ     = 7'(SNOOZE_MIN);

    // Time of day held in binary; converted to BCD only for display.
    logic [CW-1:0] cnt_q;
    logic [4:0]    hh_q;
    logic [5:0]    mm_q;
    logic [5:0]    ss_q;

    logic [4:0]    al_hh_q  [N_ALARMS];
    logic [5:0]    al_mm_q  [N_ALARMS];
    logic [4:0]    snz_hh_q [N_ALARMS];
    logic [5:0]    snz_mm_q [N_ALARMS];
    logic [N_ALARMS-1:0] snz_pend_q;
    logic [N_ALARMS-1:0] ring_q;

    // ---------------- Load decode ----------------
    logic [5:0] in_hh;
    logic [7:0] in_mm;
    logic       in_valid;
    logic       ld_time_ok;
    logic       ld_alarm_ok;

    always_comb begin
        in_hh       = 6'(bus.hr_in_1) * 6'd10 + 6'(bus.hr_in_0);
        in_mm       = 8'(bus.min_in_1) * 8'd10 + 8'(bus.min_in_0);
        in_valid    = (bus.hr_in_0 <= 4'd9) && (bus.min_in_1 <= 4'd9) &&
                      (bus.min_in_0 <= 4'd9) && (in_hh <= 6'd23) && (in_mm <= 8'd59);
        ld_time_ok  = bus.LD_time && in_valid;
        ld_alarm_ok = bus.LD_alarm && in_valid && (32'(bus.alarm_sel) < N_ALARMS);
    end

    // A time load restarts the second, so it also swallows a coincident tick.
    logic tick;
    logic min_edge;
    assign tick     = (cnt_q == CNT_MAX) && !ld_time_ok;
    assign min_edge = tick && (ss_q == 6'd59);

    // ---------------- Next time and snooze target ----------------
    logic [4:0] nxt_hh;
    logic [5:0] nxt_mm;
    logic [5:0] nxt_ss;
    logic [6:0] mm_sum;
    logic [4:0] snz_hh;
    logic [5:0] snz_mm;

    always_comb begin
        nxt_hh = hh_q;
        nxt_mm = mm_q;
        nxt_ss = ss_q + 6'd1;
        if (ss_q == 6'd59) begin
            nxt_ss = 6'd0;
            if (mm_q == 6'd59) begin
                nxt_mm = 6'd0;
                nxt_hh = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
            end else begin
                nxt_mm = mm_q + 6'd1;
            end
        end

        // Snooze target is relative to the currently displayed hh:mm.
        mm_sum = 7'(mm_q) + SNZ;
        if (mm_sum >= 7'd60) begin
            snz_mm = 6'(mm_sum - 7'd60);
            snz_hh = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
        end else begin
            snz_mm = 6'(mm_sum);
            snz_hh = hh_q;
        end
    end

    // ---------------- Per-slot trigger decode ----------------
    logic [N_ALARMS-1:0] trig;
    logic [N_ALARMS-1:0] sn_fire;
    logic [N_ALARMS-1:0] ld_slot;

    always_comb begin
        trig    = '0;
        sn_fire = '0;
        ld_slot = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            ld_slot[i] = ld_alarm_ok && (bus.alarm_sel == AW'(i));
            sn_fire[i] = min_edge && bus.AL_EN[i] && snz_pend_q[i] &&
                         (nxt_hh == snz_hh_q[i]) && (nxt_mm == snz_mm_q[i]);
            trig[i]    = sn_fire[i] ||
                         (min_edge && bus.AL_EN[i] &&
                          (nxt_hh == al_hh_q[i]) && (nxt_mm == al_mm_q[i]));
        end
    end

    // ---------------- State ----------------
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt_q      <= '0;
            hh_q       <= '0;
            mm_q       <= '0;
            ss_q       <= '0;
            snz_pend_q <= '0;
            ring_q     <= '0;
            for (int i = 0; i < N_ALARMS; i++) begin
                al_hh_q[i]  <= '0;
                al_mm_q[i]  <= '0;
                snz_hh_q[i] <= '0;
                snz_mm_q[i] <= '0;
            end
        end else begin
            if (ld_time_ok) begin
                cnt_q <= '0;
                hh_q  <= in_hh[4:0];
                mm_q  <= in_mm[5:0];
                ss_q  <= 6'd0;
            end else begin
                cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
                if (tick) begin
                    hh_q <= nxt_hh;
                    mm_q <= nxt_mm;
                    ss_q <= nxt_ss;
                end
            end

            for (int i = 0; i < N_ALARMS; i++) begin
                if (ld_slot[i]) begin
                    al_hh_q[i] <= in_hh[4:0];
                    al_mm_q[i] <= in_mm[5:0];
                end
                // Disable dominates; otherwise a trigger beats stop/snooze/load.
                if (!bus.AL_EN[i]) begin
                    ring_q[i]     <= 1'b0;
                    snz_pend_q[i] <= 1'b0;
                end else if (trig[i]) begin
                    ring_q[i] <= 1'b1;
                    if (sn_fire[i]) begin
                        snz_pend_q[i] <= 1'b0;
                    end
                end else if (ld_slot[i] || bus.STOP_alarm) begin
                    ring_q[i]     <= 1'b0;
                    snz_pend_q[i] <= 1'b0;
                end else if (bus.SNOOZE && ring_q[i]) begin
                    ring_q[i]     <= 1'b0;
                    snz_pend_q[i] <= 1'b1;
                    snz_hh_q[i]   <= snz_hh;
                    snz_mm_q[i]   <= snz_mm;
                end
            end
        end
    end

    // ---------------- Display ----------------
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] t;
        logic [6:0] r;
        t = 4'd0;
        r = v;
        for (int k = 0; k < 9; k++) begin
            if (r >= 7'd10) begin
                r = r - 7'd10;
                t = t + 4'd1;
            end
        end
        return {t, 4'(r)};
    endfunction

    logic [4:0] disp_hh;
    logic [1:0] hr_tens;
    logic [7:0] mm_bcd;
    logic [7:0] ss_bcd;

    always_comb begin
        disp_hh = hh_q;
        if (bus.mode_12h) begin
            if (hh_q == 5'd0) begin
                disp_hh = 5'd12;
            end else if (hh_q > 5'd12) begin
                disp_hh = hh_q - 5'd12;
            end
        end
        hr_tens = (disp_hh >= 5'd20) ? 2'd2 : ((disp_hh >= 5'd10) ? 2'd1 : 2'd0);
        mm_bcd  = to_bcd(7'(mm_q));
        ss_bcd  = to_bcd(7'(ss_q));
    end

    assign bus.hr_out_1  = hr_tens;
    assign bus.hr_out_0  = 4'(disp_hh - 5'(hr_tens) * 5'd10);
    assign bus.min_out_1 = mm_bcd[7:4];
    assign bus.min_out_0 = mm_bcd[3:0];
    assign bus.sec_out_1 = ss_bcd[7:4];
    assign bus.sec_out_0 = ss_bcd[3:0];
    assign bus.pm        = (hh_q >= 5'd12);
    assign bus.ringing   = ring_q;
    assign bus.Alarm     = |ring_q;

endmodule
